// File: rtl/wbu_pkg.sv
// ============================================================================
// Module      : wbu_pkg
// Description : Shared definitions for the write-back unit. Holds the
//               LSU->WBU bus layout (field offsets, widths and a packed
//               struct), the WBU state encodings, and the default widths.
//               Packers and unpackers of the bus share this single layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LSU_WBU_BUS_WIDTH
`define LSU_WBU_BUS_WIDTH 119
`endif

package wbu_pkg;

    localparam int C_LSU_WBU_BUS_WIDTH = `LSU_WBU_BUS_WIDTH;
    localparam int C_INSTRET_W         = 64;

    // State encodings
    localparam logic [1:0] C_ST_IDLE   = 2'b00;
    localparam logic [1:0] C_ST_COMMIT = 2'b01;
    localparam logic [1:0] C_ST_HOLD   = 2'b10;
    localparam logic [1:0] C_ST_HALT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_COMMIT = C_ST_COMMIT,
        ST_HOLD   = C_ST_HOLD,
        ST_HALT   = C_ST_HALT
    } wbu_state_e;

    // Bus field offsets (LSB positions) and widths, MSB first in the bus
    localparam int C_CSR_WE_BIT    = 118;
    localparam int C_RESULT_LSB    = 86;
    localparam int C_RESULT_W      = 32;
    localparam int C_GR_WE_BIT     = 85;
    localparam int C_RD_LSB        = 80;
    localparam int C_RD_W          = 5;
    localparam int C_CSR_ADDR_LSB  = 68;
    localparam int C_CSR_ADDR_W    = 12;
    localparam int C_CSR_WDATA_LSB = 36;
    localparam int C_CSR_WDATA_W   = 32;
    localparam int C_JMP_FLAG_BIT  = 35;
    localparam int C_JMP_TGT_LSB   = 3;
    localparam int C_JMP_TGT_W     = 32;
    localparam int C_BREAK_BIT     = 2;
    localparam int C_EXCP_BIT      = 1;
    localparam int C_XRET_BIT      = 0;

    typedef struct packed {
        logic        csr_we;
        logic [31:0] final_result;
        logic        gr_we;
        logic [4:0]  rd;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        jmp_flag;
        logic [31:0] jmp_target;
        logic        brk;
        logic        excp_flush;
        logic        xret_flush;
    } lsu_wbu_bus_t;

endpackage

`default_nettype wire

// File: rtl/wbu_redirect.sv
// ============================================================================
// Module      : wbu_redirect
// Description : Combinational next-PC redirect resolver.
//               Priority: exception > xret > jump. With none of them set the
//               redirect flag and target are both zero.
// Ports       : excp_flush, xret_flush, jmp_flag - redirect causes
//               mtvec, mepc, jmp_target            - candidate targets
//               redirect, target                   - resolved redirect
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbu_redirect
    import wbu_pkg::*;
(
    input  logic        excp_flush,
    input  logic        xret_flush,
    input  logic        jmp_flag,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [31:0] jmp_target,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = 1'b0;
        target   = 32'h0;
        if (excp_flush) begin
            redirect = 1'b1;
            target   = mtvec;
        end else if (xret_flush) begin
            redirect = 1'b1;
            target   = mepc;
        end else if (jmp_flag) begin
            redirect = 1'b1;
            target   = jmp_target;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wbu.sv
// ============================================================================
// Module      : wbu
// Description : Write-back / commit stage. Latches the LSU->WBU bus on a
//               one-cycle valid pulse, performs the GPR and CSR writes in a
//               single COMMIT cycle, signals exception entry / xret to the
//               CSR unit, resolves the next-PC redirect and hands a commit
//               token to the IFU with a valid/ready handshake. Also keeps the
//               retired-instruction counter and the sticky ebreak halt flag.
// Ports       : clock, reset (async, active-low)
//               lsu_valid_i, lsu_wbu_bus_i        - input bus + pulse
//               csr_mtvec_i, csr_mepc_i           - trap / return vectors
//               gpr_we_o/waddr_o/wdata_o          - GPR write port
//               csr_we_o/waddr_o/wdata_o          - CSR write port
//               excp_o, xret_o                    - CSR unit strobes
//               pc_redirect_o, pc_target_o        - next-PC redirect
//               valid_o, ifu_ready_i              - commit token handshake
//               halt_o, protocol_err_o            - sticky status flags
//               instret_o                         - retired count
// Options     : WBU_COMMIT_TRACE_EN - when defined, reports every commit
//               and the halt as trace messages for difftest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbu
    import wbu_pkg::*;
#(
    parameter int BUS_W     = C_LSU_WBU_BUS_WIDTH,
    parameter int INSTRET_W = C_INSTRET_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lsu_valid_i,
    input  logic [BUS_W-1:0]     lsu_wbu_bus_i,
    input  logic [31:0]          csr_mtvec_i,
    input  logic [31:0]          csr_mepc_i,
    output logic                 gpr_we_o,
    output logic [4:0]           gpr_waddr_o,
    output logic [31:0]          gpr_wdata_o,
    output logic                 csr_we_o,
    output logic [11:0]          csr_waddr_o,
    output logic [31:0]          csr_wdata_o,
    output logic                 excp_o,
    output logic                 xret_o,
    output logic                 pc_redirect_o,
    output logic [31:0]          pc_target_o,
    output logic                 valid_o,
    input  logic                 ifu_ready_i,
    output logic                 halt_o,
    output logic                 protocol_err_o,
    output logic [INSTRET_W-1:0] instret_o
);

    wbu_state_e           r_state;
    lsu_wbu_bus_t         r_bus;
    logic                 r_halt;
    logic                 r_perr;
    logic [INSTRET_W-1:0] r_instret;
    logic                 r_redirect;
    logic [31:0]          r_target;

    logic                 w_commit;
    logic                 w_hold;
    logic                 w_live;
    logic                 w_token;
    logic                 w_redirect;
    logic [31:0]          w_target;

    assign w_commit = (r_state == ST_COMMIT);
    assign w_hold   = (r_state == ST_HOLD);
    assign w_live   = w_commit | w_hold;
    // A token goes out on a non-ebreak commit and stays up through HOLD
    assign w_token  = (w_commit & ~r_bus.brk) | w_hold;

    wbu_redirect u_redirect (
        .excp_flush (r_bus.excp_flush),
        .xret_flush (r_bus.xret_flush),
        .jmp_flag   (r_bus.jmp_flag),
        .mtvec      (csr_mtvec_i),
        .mepc       (csr_mepc_i),
        .jmp_target (r_bus.jmp_target),
        .redirect   (w_redirect),
        .target     (w_target)
    );

    // Bus register: loaded only when a new instruction is accepted, so a
    // pulse arriving while busy leaves the committing instruction intact.
    always_ff @(posedge clock) begin
        if (r_state == ST_IDLE && lsu_valid_i) begin
            r_bus <= lsu_wbu_bus_t'(lsu_wbu_bus_i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_halt     <= 1'b0;
            r_perr     <= 1'b0;
            r_instret  <= '0;
            r_redirect <= 1'b0;
            r_target   <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lsu_valid_i) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_instret <= r_instret + 1'b1;
                    // mtvec/mepc are sampled here and held for HOLD
                    r_redirect <= w_redirect;
                    r_target   <= w_target;
                    if (lsu_valid_i) begin
                        r_perr <= 1'b1;
                    end
                    if (r_bus.brk) begin
                        r_halt  <= 1'b1;
                        r_state <= ST_HALT;
                    end else if (ifu_ready_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (lsu_valid_i) begin
                        r_perr <= 1'b1;
                    end
                    if (ifu_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write strobes are single-cycle; address/data stay visible in HOLD.
    assign gpr_we_o    = w_commit & r_bus.gr_we & (r_bus.rd != 5'd0);
    assign gpr_waddr_o = w_live ? r_bus.rd           : 5'd0;
    assign gpr_wdata_o = w_live ? r_bus.final_result : 32'h0;
    assign csr_we_o    = w_commit & r_bus.csr_we;
    assign csr_waddr_o = w_live ? r_bus.csr_addr     : 12'h0;
    assign csr_wdata_o = w_live ? r_bus.csr_wdata    : 32'h0;
    assign excp_o      = w_commit & r_bus.excp_flush;
    assign xret_o      = w_commit & r_bus.xret_flush & ~r_bus.excp_flush;

    assign valid_o       = w_token;
    assign pc_redirect_o = w_hold ? r_redirect : (w_token & w_redirect);
    assign pc_target_o   = w_hold ? r_target   : (w_token ? w_target : 32'h0);

    assign halt_o         = r_halt;
    assign protocol_err_o = r_perr;
    assign instret_o      = r_instret;

`ifdef WBU_COMMIT_TRACE_EN
    always @(posedge clock) begin
        if (reset && w_commit) begin
            $display("wbu_commit instret=%0d gpr_we=%b gpr_waddr=%0d gpr_wdata=%h csr_we=%b csr_waddr=%h csr_wdata=%h redirect=%b target=%h",
                     r_instret, gpr_we_o, gpr_waddr_o, gpr_wdata_o,
                     csr_we_o, csr_waddr_o, csr_wdata_o,
                     pc_redirect_o, pc_target_o);
            if (r_bus.brk) begin
                $display("wbu_halt exit_code=%0d", r_bus.final_result);
            end
        end
    end
`endif

endmodule

`default_nettype wire
